sync_fifo_exerciser: RTL and testbench

- On-chip traffic master and checker for the 6-bit synchronous FIFO tile.
- Drives the FIFO input byte {rd_en, wr_en, dat[5:0]} and consumes its output byte {empty, full, dat[5:0]}.
- Fills the FIFO with a seeded incrementing pattern until full, then drains it until empty, checking every word read.
- Reports fill depth, error count and pass/fail; used for bring-up and self-test.

---
 rtl/sync_fifo_exerciser.sv | 177 +++++++++++++++++
 tb/tb_sync_fifo_exerciser.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_exerciser.sv
// rtl/sync_fifo_exerciser.sv - fill/drain traffic master and checker for the 6-bit sync FIFO tile
module sync_fifo_exerciser #(
    parameter int          DEPTH  = 8,
    parameter int          RD_LAT = 1,
    parameter logic [5:0]  SEED   = 6'h05,
    parameter int          CW     = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [7:0]    fifo_status,
    output logic [7:0]    fifo_ctrl,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [CW-1:0] fill_cnt,
    output logic [3:0]    err_cnt
);

    typedef enum logic [2:0] {
        IDLE, PRECHK, WR, WSETTLE, RD, RWAIT, RSETTLE, DONE
    } state_t;

    localparam logic [CW-1:0] DEPTH_C     = CW'(DEPTH);
    localparam logic [CW-1:0] TWO_DEPTH_C = CW'(2 * DEPTH);
    localparam logic [1:0]    LAT_C       = 2'(RD_LAT);

    state_t        state_q, state_d;
    logic [CW-1:0] fill_q, fill_d;
    logic [CW-1:0] rd_idx_q, rd_idx_d;
    logic [1:0]    lat_q, lat_d;
    logic [3:0]    err_q, err_d;
    logic [7:0]    ctrl_q, ctrl_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          pass_q, pass_d;
    logic          err_inc;
    logic          err_clr;

    logic       fifo_empty;
    logic       fifo_full;
    logic [5:0] fifo_rdata;

    assign fifo_empty = fifo_status[7];
    assign fifo_full  = fifo_status[6];
    assign fifo_rdata = fifo_status[5:0];

    // Next-state, counter updates and the registered FIFO control byte
    always_comb begin
        state_d  = state_q;
        fill_d   = fill_q;
        rd_idx_d = rd_idx_q;
        lat_d    = lat_q;
        busy_d   = busy_q;
        done_d   = done_q;
        pass_d   = pass_q;
        ctrl_d   = 8'h00;
        err_inc  = 1'b0;
        err_clr  = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d  = PRECHK;
                    fill_d   = '0;
                    rd_idx_d = '0;
                    done_d   = 1'b0;
                    pass_d   = 1'b0;
                    busy_d   = 1'b1;
                    err_clr  = 1'b1;
                end
            end
            PRECHK: begin
                // leftover data from a previous user of the FIFO
                if (!fifo_empty) err_inc = 1'b1;
                state_d = WR;
            end
            WR: begin
                fill_d  = fill_q + 1'b1;
                state_d = WSETTLE;
            end
            WSETTLE: begin
                if (fifo_full) begin
                    if (fill_q != DEPTH_C) err_inc = 1'b1;
                    state_d = RD;
                end else if (fill_q == TWO_DEPTH_C) begin
                    // full never asserted: stop writing and drain what we can
                    err_inc = 1'b1;
                    state_d = RD;
                end else begin
                    state_d = WR;
                end
            end
            RD: begin
                if (fifo_empty) begin
                    if (rd_idx_q != fill_q) err_inc = 1'b1;
                    state_d = DONE;
                end else begin
                    lat_d   = 2'd0;
                    state_d = RWAIT;
                end
            end
            RWAIT: begin
                // lat_q counts from 0 in the cycle rd_en is on the FIFO input
                if (lat_q == LAT_C) begin
                    if (fifo_rdata != SEED + 6'(rd_idx_q)) err_inc = 1'b1;
                    rd_idx_d = rd_idx_q + 1'b1;
                    state_d  = RSETTLE;
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end
            RSETTLE: begin
                if (rd_idx_q == TWO_DEPTH_C) begin
                    err_inc = 1'b1;
                    state_d = DONE;
                end else begin
                    state_d = RD;
                end
            end
            default: state_d = IDLE;
        endcase

        if (err_clr)
            err_d = 4'd0;
        else if (err_inc && err_q != 4'd15)
            err_d = err_q + 4'd1;
        else
            err_d = err_q;

        if (state_d == DONE && state_q != DONE) begin
            busy_d = 1'b0;
            done_d = 1'b1;
            pass_d = (err_d == 4'd0);
        end

        // Control byte is registered, so strobes are raised on entry to the
        // cycle in which the FIFO must see them
        if (state_d == WR)
            ctrl_d = {2'b01, SEED + 6'(fill_q)};
        else if (state_q == RD && state_d == RWAIT)
            ctrl_d = 8'h80;
    end

    // State and output registers; reset drops the FIFO strobes immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            fill_q   <= '0;
            rd_idx_q <= '0;
            lat_q    <= 2'd0;
            err_q    <= 4'd0;
            ctrl_q   <= 8'h00;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            fill_q   <= fill_d;
            rd_idx_q <= rd_idx_d;
            lat_q    <= lat_d;
            err_q    <= err_d;
            ctrl_q   <= ctrl_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
        end
    end

    assign fifo_ctrl = ctrl_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign fill_cnt  = fill_q;
    assign err_cnt   = err_q;

endmodule

// File: tb/tb_sync_fifo_exerciser.sv
// tb/tb_sync_fifo_exerciser.sv - scoreboard bench for sync_fifo_exerciser with a behavioural FIFO
module tb_sync_fifo_exerciser;

    typedef struct {
        logic [4:0] fill;
        logic [3:0] err;
        logic       pass;
        int         rds;
    } res_t;

    logic            clk;
    logic            rst_n;
    logic [1:0]      start_v;
    logic [1:0][7:0] status;
    logic [1:0][7:0] ctrl;
    logic [1:0]      busy_v;
    logic [1:0]      done_v;
    logic [1:0]      pass_v;
    logic [1:0][4:0] fill_v;
    logic [1:0][3:0] err_v;

    int         cap;
    bit         stuck;
    int         flip;
    int         cnt  [2];
    int         wp   [2];
    int         rp   [2];
    int         rdn  [2];
    logic [5:0] mem  [2][8];
    logic [5:0] rdata[2];

    logic [5:0] exp_wr[$];
    res_t       exp_res[$];
    int         rd_seen;
    logic [1:0] done_prev;
    int         n_vec;
    int         n_mis;

    sync_fifo_exerciser #(.DEPTH(8), .RD_LAT(1), .SEED(6'h05), .CW(5)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .fifo_status(status[0]),
        .fifo_ctrl(ctrl[0]), .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
        .fill_cnt(fill_v[0]), .err_cnt(err_v[0])
    );

    sync_fifo_exerciser #(.DEPTH(8), .RD_LAT(1), .SEED(6'h3E), .CW(5)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .fifo_status(status[1]),
        .fifo_ctrl(ctrl[1]), .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
        .fill_cnt(fill_v[1]), .err_cnt(err_v[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural FIFO per instance: capacity cap, optional stuck-low full, optional bit-0 flip on read number flip
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                cnt[i]   <= 0;
                wp[i]    <= 0;
                rp[i]    <= 0;
                rdn[i]   <= 0;
                rdata[i] <= 6'h00;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (start_v[i]) rdn[i] <= 0;
                if (ctrl[i][6] && cnt[i] < cap) begin
                    mem[i][wp[i]] <= ctrl[i][5:0];
                    wp[i]         <= (wp[i] + 1) % 8;
                end
                if (ctrl[i][7] && cnt[i] > 0) begin
                    rdata[i] <= mem[i][rp[i]] ^ ((rdn[i] + 1 == flip) ? 6'h01 : 6'h00);
                    rp[i]    <= (rp[i] + 1) % 8;
                    rdn[i]   <= rdn[i] + 1;
                end
                cnt[i] <= cnt[i] + ((ctrl[i][6] && cnt[i] < cap) ? 1 : 0)
                                 - ((ctrl[i][7] && cnt[i] > 0) ? 1 : 0);
            end
        end
    end

    assign status[0] = {cnt[0] == 0, !stuck && cnt[0] == cap, rdata[0]};
    assign status[1] = {cnt[1] == 0, !stuck && cnt[1] == cap, rdata[1]};

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_mis++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic monitor();
        res_t r;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (ctrl[i][6] || ctrl[i][7])
                    chk("rd_wr_exclusive", int'(ctrl[i][6] & ctrl[i][7]), 0);
                if (ctrl[i][7]) rd_seen++;
                if (ctrl[i][6]) begin
                    if (exp_wr.size() == 0)
                        chk("unexpected_write", 1, 0);
                    else
                        chk("write_data", int'(ctrl[i][5:0]), int'(exp_wr.pop_front()));
                end
                if (done_v[i] && !done_prev[i]) begin
                    if (exp_res.size() == 0) begin
                        chk("unexpected_done", 1, 0);
                    end else begin
                        r = exp_res.pop_front();
                        chk("fill_cnt", int'(fill_v[i]), int'(r.fill));
                        chk("err_cnt", int'(err_v[i]), int'(r.err));
                        chk("pass", int'(pass_v[i]), int'(r.pass));
                        chk("read_pulses", rd_seen, r.rds);
                    end
                    rd_seen = 0;
                end
                done_prev[i] = done_v[i];
            end
        end
    endtask

    task automatic pulse_start(input int inst);
        @(negedge clk);
        start_v[inst] = 1'b1;
        @(negedge clk);
        start_v[inst] = 1'b0;
    endtask

    task automatic run(input int inst, input int cap_v, input bit stuck_v, input int flip_v,
                       input int nwr, input logic [5:0] seed, input logic [4:0] fill,
                       input logic [3:0] err, input bit ps, input int rds, input bit extra);
        res_t       r;
        logic [5:0] w;
        cap   = cap_v;
        stuck = stuck_v;
        flip  = flip_v;
        for (int i = 0; i < nwr; i++) begin
            w = seed + 6'(i);
            exp_wr.push_back(w);
        end
        r.fill = fill;
        r.err  = err;
        r.pass = ps;
        r.rds  = rds;
        exp_res.push_back(r);
        rd_seen = 0;
        pulse_start(inst);
        if (extra) begin
            repeat (5) @(negedge clk);
            pulse_start(inst);
        end
        for (int k = 0; k < 600; k++) begin
            if (exp_res.size() == 0) break;
            @(negedge clk);
        end
        if (exp_res.size() != 0) begin
            chk("run_timeout", 1, 0);
            exp_res.delete();
        end
        repeat (3) @(negedge clk);
        chk("done_held", int'(done_v[inst]), 1);
        chk("busy_after_done", int'(busy_v[inst]), 0);
        chk("writes_left", exp_wr.size(), 0);
        exp_wr.delete();
    endtask

    task automatic reset_mid_run();
        int seen;
        cap   = 8;
        stuck = 1'b0;
        flip  = 0;
        exp_wr.push_back(6'h05);
        exp_wr.push_back(6'h06);
        exp_wr.push_back(6'h07);
        pulse_start(0);
        seen = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (ctrl[0][6]) seen++;
            if (seen == 3) break;
        end
        chk("third_write_seen", seen, 3);
        #2 rst_n = 1'b0;
        #1;
        chk("async_ctrl_clear", int'(ctrl[0]), 0);
        chk("async_busy_clear", int'(busy_v[0]), 0);
        repeat (2) @(negedge clk);
        chk("reset_writes_left", exp_wr.size(), 0);
        exp_wr.delete();
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_fill", int'(fill_v[0]), 0);
        chk("post_reset_err", int'(err_v[0]), 0);
        chk("post_reset_done", int'(done_v[0]), 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        start_v   = 2'b00;
        cap       = 8;
        stuck     = 1'b0;
        flip      = 0;
        rd_seen   = 0;
        done_prev = 2'b00;
        n_vec     = 0;
        n_mis     = 0;
        fork
            monitor();
        join_none
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("reset_ctrl", int'(ctrl[i]), 0);
            chk("reset_busy", int'(busy_v[i]), 0);
            chk("reset_done", int'(done_v[i]), 0);
            chk("reset_pass", int'(pass_v[i]), 0);
            chk("reset_fill", int'(fill_v[i]), 0);
            chk("reset_err", int'(err_v[i]), 0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        run(0, 8, 1'b0, 0,  8, 6'h05,  5'd8, 4'd0, 1'b1, 8, 1'b0);
        run(1, 8, 1'b0, 0,  8, 6'h3E,  5'd8, 4'd0, 1'b1, 8, 1'b0);
        run(0, 4, 1'b0, 0,  4, 6'h05,  5'd4, 4'd1, 1'b0, 4, 1'b0);
        run(0, 8, 1'b0, 3,  8, 6'h05,  5'd8, 4'd1, 1'b0, 8, 1'b0);
        run(0, 8, 1'b1, 0, 16, 6'h05, 5'd16, 4'd2, 1'b0, 8, 1'b0);
        run(0, 8, 1'b0, 0,  8, 6'h05,  5'd8, 4'd0, 1'b1, 8, 1'b0);
        reset_mid_run();
        run(0, 8, 1'b0, 0,  8, 6'h05,  5'd8, 4'd0, 1'b1, 8, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
